// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch path.
// Holds datapath widths, the NOP encoding, the PC increment, the default
// reset PC, the fetch-state encoding and the prefetch entry layout.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP          = 32'h0000_0004;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE: nothing outstanding; WAIT: response will be kept;
    // DROP: response belongs to a squashed fetch and is discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between imem and IF/ID.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (to empty)
//   push, push_data write one entry at the tail
//   pop             retire the head entry
//   flush           discard everything (wins over push/pop)
//   count           current occupancy
//   head            raw head entry (meaningful only when count != 0)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers responses in a prefetch FIFO and feeds the IF/ID register.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/imem_addr        fetch request (combinational) and its address
//   imem_ready/imem_rdata     response strobe and instruction word
//   stall                     downstream hold, head not consumed
//   redirect/redirect_pc      taken branch/jump from EX and its target
//   out_valid/out_pc/out_instr FIFO head (0 / NOP when empty)
//   out_write                 IF/ID write enable (head consumed this cycle)
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_write
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] req_pc_r;

    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    count_next_s;
    fetch_entry_t      head_s;
    fetch_entry_t      push_data_s;
    logic              busy_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;
    logic              issue_s;

    // Push/pop/issue decisions. A new request may go out in the same cycle
    // the previous response lands, as long as the FIFO will have a free slot
    // for it after this cycle's push and pop.
    always_comb begin
        busy_s        = (state_r != IDLE);
        valid_s       = (count_s != '0);
        push_s        = (state_r == WAIT) & imem_ready & ~redirect;
        pop_s         = valid_s & ~stall & ~redirect;
        count_next_s  = {1'b0, count_s} + {{CNT_W{1'b0}}, push_s}
                        - {{CNT_W{1'b0}}, pop_s};
        issue_s       = ~rst & ~redirect & (~busy_s | imem_ready)
                        & (count_next_s < DEPTH_W);
        push_data_s.pc    = req_pc_r;
        push_data_s.instr = imem_rdata;
    end

    // Fetch FSM and PC. Redirect wins; a request still in flight without its
    // response this cycle is marked DROP so its late data is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= '0;
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            state_r    <= (busy_s && !imem_ready) ? DROP : IDLE;
        end else if (issue_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + PC_STEP;
            state_r    <= WAIT;
        end else if (busy_s && imem_ready) begin
            state_r    <= IDLE;
        end else begin
            state_r    <= state_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect),
        .count     (count_s),
        .head      (head_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = fetch_pc_r;
    assign out_valid = valid_s;
    assign out_pc    = valid_s ? head_s.pc    : '0;
    assign out_instr = valid_s ? head_s.instr : NOP_INSTR;
    assign out_write = pop_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle memory model
// returning addr ^ 32'hA5A5_0000. A second instance with a high RESET_PC
// runs in lockstep to cover PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_write;

    logic        h_imem_req;
    logic [31:0] h_imem_addr;
    logic        h_out_valid;
    logic [31:0] h_out_pc;
    logic [31:0] h_out_instr;
    logic        h_out_write;

    logic        mem_en;
    int          checks   = 0;
    int          failures = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_write   (out_write)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_hi (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (h_imem_req),
        .imem_addr   (h_imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (h_out_valid),
        .out_pc      (h_out_pc),
        .out_instr   (h_out_instr),
        .out_write   (h_out_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory samples the request at the edge and answers in the
    // following cycle when enabled. Returns 2 time units after the edge.
    task automatic step();
        logic        r;
        logic [31:0] a;
        r = imem_req;
        a = imem_addr;
        @(posedge clk);
        #1;
        if (mem_en) begin
            imem_ready = r;
            imem_rdata = a ^ KEY;
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'h0;
        end
        #1;
    endtask

    // Leaves the bench settled in the first cycle after reset release (C0).
    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_en      = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_en      = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_pc",    out_pc,             32'd0);
        chk("rst_instr", out_instr,          32'd0);

        // ---- streaming, stall=0 ----
        do_reset();
        chk("c0_req",     {31'd0, imem_req},  32'd1);
        chk("c0_addr",    imem_addr,          32'h0000_0000);
        chk("c0_valid",   {31'd0, out_valid}, 32'd0);
        chk("c0_write",   {31'd0, out_write}, 32'd0);
        chk("hi_c0_addr", h_imem_addr,        32'hFFFF_FFF8);
        step();
        #1;
        chk("c1_valid",   {31'd0, out_valid}, 32'd0);
        chk("c1_addr",    imem_addr,          32'h0000_0004);
        chk("hi_c1_addr", h_imem_addr,        32'hFFFF_FFFC);
        step();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("str_valid", {31'd0, out_valid}, 32'd1);
            chk("str_pc",    out_pc,             32'(4 * i));
            chk("str_instr", out_instr,          32'(4 * i) ^ KEY);
            chk("str_write", {31'd0, out_write}, 32'd1);
            chk("str_addr",  imem_addr,          32'(4 * (i + 2)));
            chk("hi_addr",   h_imem_addr,        32'hFFFF_FFF8 + 32'(4 * (i + 2)));
            chk("hi_pc",     h_out_pc,           32'hFFFF_FFF8 + 32'(4 * i));
            step();
            #1;
        end

        // ---- stall held: FIFO fills, requests stop, head frozen ----
        do_reset();
        step();
        step();
        stall = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("stl_valid", {31'd0, out_valid}, 32'd1);
            chk("stl_pc",    out_pc,             32'd0);
            chk("stl_write", {31'd0, out_write}, 32'd0);
            chk("stl_req",   {31'd0, imem_req},  32'd0);
            step();
            #1;
        end
        stall = 1'b0;
        #1;
        chk("rel_pc0",    out_pc,             32'd0);
        chk("rel_write0", {31'd0, out_write}, 32'd1);
        chk("rel_req",    {31'd0, imem_req},  32'd1);
        chk("rel_addr",   imem_addr,          32'd8);
        step();
        #1;
        chk("rel_pc1",    out_pc,             32'd4);
        chk("rel_write1", {31'd0, out_write}, 32'd1);
        step();
        #1;
        chk("rel_pc2",    out_pc,             32'd8);
        chk("rel_instr2", out_instr,          32'd8 ^ KEY);

        // ---- redirect with a request outstanding and no response ----
        do_reset();
        mem_en = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        chk("rdo_req",   {31'd0, imem_req},  32'd0);
        chk("rdo_write", {31'd0, out_write}, 32'd0);
        step();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        mem_en     = 1'b1;
        #1;
        chk("rdo_late_req",  {31'd0, imem_req},  32'd1);
        chk("rdo_late_addr", imem_addr,          32'h0000_0100);
        chk("rdo_late_vld",  {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("rdo_empty", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("rdo_valid", {31'd0, out_valid}, 32'd1);
        chk("rdo_pc",    out_pc,             32'h0000_0100);
        chk("rdo_instr", out_instr,          32'hA5A5_0100);

        // ---- redirect coinciding with response and pop ----
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk("rdp_write", {31'd0, out_write}, 32'd0);
        chk("rdp_req",   {31'd0, imem_req},  32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("rdp_empty", {31'd0, out_valid}, 32'd0);
        chk("rdp_req2",  {31'd0, imem_req},  32'd1);
        chk("rdp_addr",  imem_addr,          32'h0000_0200);
        step();
        #1;
        chk("rdp_empty2", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("rdp_pc",    out_pc,    32'h0000_0200);
        chk("rdp_instr", out_instr, 32'hA5A5_0200);

        // ---- asynchronous reset with a request in flight ----
        do_reset();
        step();
        step();
        imem_ready = 1'b0;
        mem_en     = 1'b0;
        #1;
        chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_pre_req",   {31'd0, imem_req},  32'd0);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc",    out_pc,             32'd0);
        chk("arst_instr", out_instr,          32'd0);
        chk("arst_req",   {31'd0, imem_req},  32'd0);
        chk("arst_write", {31'd0, out_write}, 32'd0);
        step();
        step();
        imem_ready = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        #1;
        chk("arst_stale_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_stale_req",   {31'd0, imem_req},  32'd0);
        step();
        rst    = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("arst_rel_req",   {31'd0, imem_req},  32'd1);
        chk("arst_rel_addr",  imem_addr,          32'd0);
        chk("arst_rel_valid", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("arst_c1_valid", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        chk("arst_c2_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_c2_pc",    out_pc,             32'd0);
        chk("arst_c2_instr", out_instr,          KEY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
